// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, FSM state type and divisor lookup for the SPART driver
package spart_pkg;

  localparam logic [1:0] IOADDR_DATA  = 2'b00;
  localparam logic [1:0] IOADDR_DIVLO = 2'b10;
  localparam logic [1:0] IOADDR_DIVHI = 2'b11;

  localparam logic [15:0] DIV_4800_DEF  = 16'h0515;
  localparam logic [15:0] DIV_9600_DEF  = 16'h028A;
  localparam logic [15:0] DIV_19200_DEF = 16'h0145;
  localparam logic [15:0] DIV_38400_DEF = 16'h00A2;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RD,
    RD_HOLD,
    WR,
    WR_HOLD
  } state_t;

  function automatic logic [15:0] div_sel(input logic [1:0] br,
                                          input logic [15:0] d0, input logic [15:0] d1,
                                          input logic [15:0] d2, input logic [15:0] d3);
    case (br)
      2'b00:   return d0;
      2'b01:   return d1;
      2'b10:   return d2;
      default: return d3;
    endcase
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// rtl/spart_driver_if.sv - SPART control/status signals between bus master and SPART
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, output iorw, output ioaddr, input rda, input tbr);
  modport slave  (input iocs, input iorw, input ioaddr, output rda, output tbr);
endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - byte FIFO for the echo buffer, power-of-two depth, wrapping pointers
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_din,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/spart_driver.sv
// rtl/spart_driver.sv - SPART bus master: programs the baud divisor, then echoes RX bytes back to TX
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = DIV_4800_DEF,
  parameter logic [15:0] DIV_9600  = DIV_9600_DEF,
  parameter logic [15:0] DIV_19200 = DIV_19200_DEF,
  parameter logic [15:0] DIV_38400 = DIV_38400_DEF,
  parameter int          FIFO_DEPTH = 4,
  localparam int         CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        br_cfg,
  spart_driver_if.master    bus,
  inout  wire  [7:0]        databus,
  output logic [CNT_W-1:0]  fifo_cnt
);

  state_t      r_state;
  logic [1:0]  r_br_q;
  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_dout;

  logic [15:0] w_div;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_div  = div_sel(r_br_q, DIV_4800, DIV_9600, DIV_19200, DIV_38400);
  assign w_push = (r_state == RD);
  assign w_pop  = (r_state == WR);

  assign bus.iocs   = r_iocs;
  assign bus.iorw   = r_iorw;
  assign bus.ioaddr = r_ioaddr;
  assign databus    = (r_iocs && !r_iorw) ? r_dout : 8'hzz;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (databus),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= CFG_LO;
      r_br_q   <= br_cfg;
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= IOADDR_DATA;
      r_dout   <= 8'h00;
    end else begin
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= IOADDR_DATA;
      case (r_state)
        // CFG_LO is entered with the bus idle; the low-byte write is issued
        // first, and the cycle that finds it on the bus moves on to the high byte.
        CFG_LO: begin
          r_iocs <= 1'b1;
          r_iorw <= 1'b0;
          if (!r_iocs) begin
            r_ioaddr <= IOADDR_DIVLO;
            r_dout   <= w_div[7:0];
          end else begin
            r_ioaddr <= IOADDR_DIVHI;
            r_dout   <= w_div[15:8];
            r_state  <= CFG_HI;
          end
        end
        CFG_HI: r_state <= IDLE;
        IDLE: begin
          if (br_cfg != r_br_q) begin
            r_br_q  <= br_cfg;
            r_state <= CFG_LO;
          end else if (bus.rda && !w_full) begin
            r_iocs  <= 1'b1;
            r_state <= RD;
          end else if (bus.tbr && !w_empty) begin
            r_iocs  <= 1'b1;
            r_iorw  <= 1'b0;
            r_dout  <= w_head;
            r_state <= WR;
          end
        end
        RD:      r_state <= RD_HOLD;
        RD_HOLD: r_state <= IDLE;
        WR:      r_state <= WR_HOLD;
        WR_HOLD: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spart_driver.sv
// tb/tb_spart_driver.sv - self-checking bench for spart_driver with a behavioural SPART model
module tb_spart_driver;

  localparam logic [15:0] DIVS [4] = '{16'h0515, 16'h028A, 16'h0145, 16'h00A2};

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    int         cyc;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] br_cfg = 2'b01;
  wire  [7:0] databus;
  logic [2:0] fifo_cnt;
  logic [7:0] rx_cur = 8'h00;
  logic       sp_drive;
  bit         next_rda;

  spart_driver_if bus();

  spart_driver dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (bus),
    .databus  (databus),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;

  assign sp_drive = bus.iocs && bus.iorw && (bus.ioaddr == 2'b00);
  assign databus  = sp_drive ? rx_cur : 8'hzz;

  acc_t       acc_log [$];
  logic [7:0] rxq [$];
  logic [7:0] tx_log [$];
  int         model_cnt = 0;
  int         cyc = 0;
  int         rda_rise_cyc = 0;
  int         proto_err = 0;
  bit         rd_pending = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // SPART model: serves reads from rxq, records every access, tracks expected occupancy.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      model_cnt  = 0;
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        rd_pending = 1'b0;
        void'(rxq.pop_front());
      end
      checks++;
      if (fifo_cnt !== 3'(model_cnt)) begin
        errors++;
        $display("FAIL fifo_cnt_track cyc=%0d got=%0d expected=%0d", cyc, fifo_cnt, model_cnt);
      end
      if (bus.iocs) begin
        acc_log.push_back('{bus.iorw, bus.ioaddr, databus, cyc});
        if (bus.ioaddr == 2'b01) proto_err++;
        if (bus.iorw && bus.ioaddr == 2'b00) begin
          rd_pending = 1'b1;
          model_cnt++;
        end else if (!bus.iorw && bus.ioaddr == 2'b00) begin
          tx_log.push_back(databus);
          model_cnt--;
        end else if (bus.iorw) begin
          proto_err++;
        end
      end else if (bus.iorw !== 1'b1 || bus.ioaddr !== 2'b00) begin
        proto_err++;
      end
    end
    next_rda = (rxq.size() != 0) && !rd_pending;
    if (next_rda && !bus.rda) rda_rise_cyc = cyc;
    bus.rda = next_rda;
    rx_cur  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_tx(input int n, input int budget);
    int t = 0;
    while (tx_log.size() < n && t < budget) begin
      step(1);
      t++;
    end
    checks++;
    if (tx_log.size() < n) begin
      errors++;
      $display("FAIL wait_tx timeout got=%0d expected=%0d", tx_log.size(), n);
    end
  endtask

  task automatic wait_cnt(input int n, input int budget);
    int t = 0;
    while (fifo_cnt != 3'(n) && t < budget) begin
      step(1);
      t++;
    end
    checks++;
    if (fifo_cnt != 3'(n)) begin
      errors++;
      $display("FAIL wait_cnt timeout got=%0d expected=%0d", fifo_cnt, n);
    end
  endtask

  task automatic check_cfg_pair(input string name, input int idx, input logic [1:0] br);
    logic [15:0] d;
    d = DIVS[br];
    checks++;
    if (acc_log.size() < idx + 2) begin
      errors++;
      $display("FAIL %s_count got=%0d expected>=%0d", name, acc_log.size(), idx + 2);
    end else begin
      if ({acc_log[idx].rw, acc_log[idx].addr, acc_log[idx].data} !== {1'b0, 2'b10, d[7:0]}) begin
        errors++;
        $display("FAIL %s_lo got=%b/%b/%h expected=0/10/%h", name, acc_log[idx].rw,
                 acc_log[idx].addr, acc_log[idx].data, d[7:0]);
      end
      checks++;
      if ({acc_log[idx+1].rw, acc_log[idx+1].addr, acc_log[idx+1].data} !== {1'b0, 2'b11, d[15:8]}) begin
        errors++;
        $display("FAIL %s_hi got=%b/%b/%h expected=0/11/%h", name, acc_log[idx+1].rw,
                 acc_log[idx+1].addr, acc_log[idx+1].data, d[15:8]);
      end
      checks++;
      if (acc_log[idx+1].cyc !== acc_log[idx].cyc + 1) begin
        errors++;
        $display("FAIL %s_adjacent got=%0d expected=%0d", name, acc_log[idx+1].cyc, acc_log[idx].cyc + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    br_cfg = 2'b01;
    bus.tbr = 1'b0;
    step(3);
    checks++; if (bus.iocs !== 1'b0)     begin errors++; $display("FAIL reset_iocs got=%b expected=0", bus.iocs); end
    checks++; if (bus.iorw !== 1'b1)     begin errors++; $display("FAIL reset_iorw got=%b expected=1", bus.iorw); end
    checks++; if (bus.ioaddr !== 2'b00)  begin errors++; $display("FAIL reset_ioaddr got=%b expected=00", bus.ioaddr); end
    checks++; if (fifo_cnt !== 3'd0)     begin errors++; $display("FAIL reset_fifo_cnt got=%0d expected=0", fifo_cnt); end
    acc_log.delete();
    rst = 1'b1;
    step(6);
    check_cfg_pair("reset_cfg", 0, 2'b01);
    checks++;
    if (acc_log.size() != 2) begin
      errors++;
      $display("FAIL reset_extra_access got=%0d expected=2", acc_log.size());
    end
    checks++;
    if (bus.iocs !== 1'b0 || bus.iorw !== 1'b1) begin
      errors++;
      $display("FAIL reset_idle_after_cfg got=%b%b expected=01", bus.iocs, bus.iorw);
    end
  endtask

  task automatic test_single_echo();
    int rd_c = -1;
    int wr_c = -1;
    acc_log.delete();
    tx_log.delete();
    bus.tbr = 1'b1;
    rxq.push_back(8'h41);
    wait_tx(1, 40);
    step(3);
    checks++;
    if (tx_log.size() != 1 || tx_log[0] !== 8'h41) begin
      errors++;
      $display("FAIL echo_data got_n=%0d expected=1 byte 41", tx_log.size());
    end
    foreach (acc_log[i]) begin
      if (rd_c < 0 && acc_log[i].rw && acc_log[i].addr == 2'b00) rd_c = acc_log[i].cyc;
      if (wr_c < 0 && !acc_log[i].rw && acc_log[i].addr == 2'b00) wr_c = acc_log[i].cyc;
    end
    checks++;
    if (rd_c != rda_rise_cyc + 1) begin
      errors++;
      $display("FAIL echo_rd_latency got=%0d expected=%0d", rd_c, rda_rise_cyc + 1);
    end
    checks++;
    if (wr_c != rd_c + 3) begin
      errors++;
      $display("FAIL echo_wr_latency got=%0d expected=%0d", wr_c, rd_c + 3);
    end
    checks++;
    if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL echo_cnt_end got=%0d expected=0", fifo_cnt); end
  endtask

  task automatic test_full();
    logic [7:0] sent [5];
    bus.tbr = 1'b0;
    tx_log.delete();
    foreach (sent[i]) begin
      sent[i] = 8'($urandom);
      rxq.push_back(sent[i]);
    end
    step(40);
    checks++; if (fifo_cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d expected=4", fifo_cnt); end
    checks++; if (rxq.size() != 1)   begin errors++; $display("FAIL full_pending got=%0d expected=1", rxq.size()); end
    checks++; if (bus.rda !== 1'b1)  begin errors++; $display("FAIL full_rda got=%b expected=1", bus.rda); end
    checks++; if (tx_log.size() != 0) begin errors++; $display("FAIL full_no_tx got=%0d expected=0", tx_log.size()); end
    bus.tbr = 1'b1;
    wait_tx(5, 150);
    step(4);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== sent[i]) begin
        errors++;
        $display("FAIL full_order idx=%0d got=%h expected=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'h00, sent[i]);
      end
    end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL full_cnt_end got=%0d expected=0", fifo_cnt); end
  endtask

  task automatic test_reconfig();
    logic [7:0] b0;
    logic [7:0] b1;
    int t = 0;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    bus.tbr = 1'b0;
    tx_log.delete();
    rxq.push_back(b0);
    wait_cnt(1, 30);
    rxq.push_back(b1);
    while (!(bus.iocs && bus.iorw) && t < 30) begin
      step(1);
      t++;
    end
    checks++;
    if (!(bus.iocs && bus.iorw)) begin errors++; $display("FAIL reconfig_rd_timeout got=0 expected=1"); end
    br_cfg = 2'b11;
    acc_log.delete();
    step(12);
    check_cfg_pair("reconfig", 0, 2'b11);
    checks++;
    if (acc_log.size() != 2) begin errors++; $display("FAIL reconfig_extra got=%0d expected=2", acc_log.size()); end
    checks++;
    if (fifo_cnt !== 3'd2) begin errors++; $display("FAIL reconfig_fifo_kept got=%0d expected=2", fifo_cnt); end
    bus.tbr = 1'b1;
    wait_tx(2, 40);
    checks++;
    if (tx_log.size() < 2 || tx_log[0] !== b0 || tx_log[1] !== b1) begin
      errors++;
      $display("FAIL reconfig_echo got_n=%0d expected=%h,%h", tx_log.size(), b0, b1);
    end
  endtask

  task automatic test_reset_mid_wr();
    logic [7:0] n;
    int t = 0;
    bus.tbr = 1'b0;
    rxq.push_back(8'($urandom));
    rxq.push_back(8'($urandom));
    wait_cnt(2, 40);
    bus.tbr = 1'b1;
    while (!(bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) && t < 30) begin
      step(1);
      t++;
    end
    checks++;
    if (!(bus.iocs && !bus.iorw)) begin errors++; $display("FAIL rstwr_wr_timeout got=0 expected=1"); end
    rst = 1'b0;
    #1;
    checks++; if (bus.iocs !== 1'b0) begin errors++; $display("FAIL rstwr_iocs got=%b expected=0", bus.iocs); end
    checks++; if (bus.iorw !== 1'b1) begin errors++; $display("FAIL rstwr_bus_released got=%b expected=1", bus.iorw); end
    checks++; if (fifo_cnt !== 3'd0) begin errors++; $display("FAIL rstwr_cnt got=%0d expected=0", fifo_cnt); end
    n = 8'($urandom);
    rxq.push_back(n);
    step(2);
    acc_log.delete();
    tx_log.delete();
    rst = 1'b1;
    wait_tx(1, 40);
    check_cfg_pair("rstwr_cfg_first", 0, br_cfg);
    checks++;
    if (tx_log.size() < 1 || tx_log[0] !== n) begin
      errors++;
      $display("FAIL rstwr_echo got_n=%0d expected=%h", tx_log.size(), n);
    end
  endtask

  task automatic test_random();
    logic [7:0] sent [$];
    logic [1:0] new_br;
    int ncfg = 0;
    int first_cfg = -1;
    acc_log.delete();
    tx_log.delete();
    new_br = br_cfg ^ 2'($urandom_range(1, 3));
    for (int i = 0; i < 200; i++) begin
      step(1);
      bus.tbr = 1'($urandom);
      if (i % 12 == 0 && sent.size() < 16) begin
        sent.push_back(8'($urandom));
        rxq.push_back(sent[sent.size()-1]);
      end
      if (i == 60) br_cfg = new_br;
    end
    bus.tbr = 1'b1;
    wait_tx(sent.size(), 400);
    step(4);
    checks++;
    if (tx_log.size() != sent.size()) begin
      errors++;
      $display("FAIL rand_count got=%0d expected=%0d", tx_log.size(), sent.size());
    end
    foreach (sent[i]) begin
      checks++;
      if (i >= tx_log.size() || tx_log[i] !== sent[i]) begin
        errors++;
        $display("FAIL rand_order idx=%0d got=%h expected=%h", i, (i < tx_log.size()) ? tx_log[i] : 8'h00, sent[i]);
      end
    end
    foreach (acc_log[i]) begin
      if (acc_log[i].addr[1]) begin
        ncfg++;
        if (first_cfg < 0) first_cfg = i;
      end
    end
    checks++;
    if (ncfg != 2) begin errors++; $display("FAIL rand_cfg_count got=%0d expected=2", ncfg); end
    if (first_cfg >= 0) check_cfg_pair("rand_cfg", first_cfg, new_br);
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_full();
    test_reconfig();
    test_reset_mid_wr();
    test_random();
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL bus_protocol got=%0d expected=0", proto_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
